regfile_access_ctrl: RTL and testbench

- Initiator side of the register file interface.
- Drives the register file's read indices and its single write port: reg_write, read_index1/2, write_index, write_data.
- Consumes read_data1/2 from the register file.
- Sits between decode and execute in the multicycle RISC-V core:
  - captures source operands for issued instructions;
  - arbitrates ALU and late load writebacks onto the one write port;
  - stalls issue on a load-pending scoreboard.

---
 rtl/regfile_access_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_ctrl.sv
// Register file access controller: issues source-operand reads, captures
// operands for execute, arbitrates ALU and buffered load writebacks onto the
// single register file write port, and stalls issue on pending loads.
module regfile_access_ctrl #(
  parameter int NUM_REGS      = 32,
  parameter int IDX_W         = 5,
  parameter int DATA_W        = 32,
  parameter int LD_FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [IDX_W-1:0]  issue_rs1,
  input  logic [IDX_W-1:0]  issue_rs2,
  input  logic [IDX_W-1:0]  issue_rd,
  input  logic              issue_rd_is_load,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_rs1_data,
  output logic [DATA_W-1:0] op_rs2_data,
  input  logic              alu_wb_valid,
  input  logic [IDX_W-1:0]  alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  input  logic              ld_wb_valid,
  output logic              ld_wb_ready,
  input  logic [IDX_W-1:0]  ld_wb_rd,
  input  logic [DATA_W-1:0] ld_wb_data,
  output logic              reg_write,
  output logic [IDX_W-1:0]  write_index,
  output logic [DATA_W-1:0] write_data,
  output logic [IDX_W-1:0]  read_index1,
  output logic [IDX_W-1:0]  read_index2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2
);

  localparam int PTR_W = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(LD_FIFO_DEPTH + 1);

  logic [NUM_REGS-1:0] pending_r;
  logic [NUM_REGS-1:0] pending_nxt_s;
  logic [IDX_W-1:0]    fifo_rd_r   [LD_FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_r [LD_FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              sel_valid_s;
  logic [IDX_W-1:0]  sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              hazard_s;
  logic              accept_s;
  logic [DATA_W-1:0] cap1_s;
  logic [DATA_W-1:0] cap2_s;

  // Full is taken from the registered count, so a pop cannot reopen the
  // input in the same cycle.
  assign fifo_full_s  = (count_r == CNT_W'(LD_FIFO_DEPTH));
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign ld_wb_ready  = !fifo_full_s;
  assign push_s       = ld_wb_valid && !fifo_full_s;
  assign pop_s        = !alu_wb_valid && !fifo_empty_s;

  assign read_index1 = issue_rs1;
  assign read_index2 = issue_rs2;

  // Write port arbitration: ALU results always win, buffered loads fill idle cycles.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_rd_s    = {IDX_W{1'b0}};
    sel_data_s  = {DATA_W{1'b0}};
    if (alu_wb_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = alu_wb_rd;
      sel_data_s  = alu_wb_data;
    end else if (!fifo_empty_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = fifo_rd_r[rd_ptr_r];
      sel_data_s  = fifo_data_r[rd_ptr_r];
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Writes to x0 are consumed but never reach the register file; nothing is
  // written while reset is held.
  assign reg_write   = !rst && sel_valid_s && (sel_rd_s != {IDX_W{1'b0}});
  assign write_index = sel_rd_s;
  assign write_data  = sel_data_s;

  assign hazard_s = (pending_r[issue_rs1] && (issue_rs1 != {IDX_W{1'b0}})) ||
                    (pending_r[issue_rs2] && (issue_rs2 != {IDX_W{1'b0}})) ||
                    (issue_rd_is_load && pending_r[issue_rd]);
  assign issue_ready = (!op_valid || op_ready) && !hazard_s;
  assign accept_s    = issue_valid && issue_ready;

  // Operand selection: x0 reads zero, a same-cycle write is forwarded ahead
  // of the (not yet updated) register file.
  always_comb begin
    if (issue_rs1 == {IDX_W{1'b0}}) begin
      cap1_s = {DATA_W{1'b0}};
    end else if (reg_write && (write_index == issue_rs1)) begin
      cap1_s = write_data;
    end else begin
      cap1_s = read_data1;
    end
    if (issue_rs2 == {IDX_W{1'b0}}) begin
      cap2_s = {DATA_W{1'b0}};
    end else if (reg_write && (write_index == issue_rs2)) begin
      cap2_s = write_data;
    end else begin
      cap2_s = read_data2;
    end
  end

  // Scoreboard next state: clear on load writeback pop, set on accepted load issue.
  always_comb begin
    pending_nxt_s = pending_r;
    if (pop_s) begin
      pending_nxt_s[fifo_rd_r[rd_ptr_r]] = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (accept_s && issue_rd_is_load && (issue_rd != {IDX_W{1'b0}})) begin
      pending_nxt_s[issue_rd] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Load writeback FIFO storage, pointers, occupancy and scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {NUM_REGS{1'b0}};
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
        fifo_rd_r[i]   <= {IDX_W{1'b0}};
        fifo_data_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      pending_r <= pending_nxt_s;
      if (push_s) begin
        fifo_rd_r[wr_ptr_r]   <= ld_wb_rd;
        fifo_data_r[wr_ptr_r] <= ld_wb_data;
        wr_ptr_r <= (wr_ptr_r == PTR_W'(LD_FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(LD_FIFO_DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Operand capture register: load on accept, hold while stalled, drain when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_valid    <= 1'b0;
      op_rs1_data <= {DATA_W{1'b0}};
      op_rs2_data <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      op_valid    <= 1'b1;
      op_rs1_data <= cap1_s;
      op_rs2_data <= cap2_s;
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed self-checking bench for regfile_access_ctrl with a small
// register file model behind the read/write ports.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready, issue_rd_is_load;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        op_valid, op_ready;
  logic [31:0] op_rs1_data, op_rs2_data;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        ld_wb_valid, ld_wb_ready;
  logic [4:0]  ld_wb_rd;
  logic [31:0] ld_wb_data;
  logic        reg_write;
  logic [4:0]  write_index, read_index1, read_index2;
  logic [31:0] write_data, read_data1, read_data2;

  logic [31:0] rf [32];
  logic        rf_clr, pl_en;
  logic [4:0]  pl_idx;
  logic [31:0] pl_data;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_access_ctrl dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_rd_is_load(issue_rd_is_load),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .ld_wb_valid(ld_wb_valid), .ld_wb_ready(ld_wb_ready),
    .ld_wb_rd(ld_wb_rd), .ld_wb_data(ld_wb_data),
    .reg_write(reg_write), .write_index(write_index), .write_data(write_data),
    .read_index1(read_index1), .read_index2(read_index2),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  // Register file model: clear, preload, or write from the DUT write port.
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (pl_en) begin
      rf[pl_idx] <= pl_data;
    end else if (reg_write) begin
      rf[write_index] <= write_data;
    end
  end

  assign read_data1 = rf[read_index1];
  assign read_data2 = rf[read_index2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rf_clr = 1'b1;
    tick(); tick();
    n_checks++; if (op_valid !== 1'b0) $display("FAIL reset_op_valid: got %0h want 0", op_valid); else n_pass++;
    n_checks++; if (op_rs1_data !== 32'h0) $display("FAIL reset_op_rs1: got %0h want 0", op_rs1_data); else n_pass++;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %0h want 1", issue_ready); else n_pass++;
    n_checks++; if (ld_wb_ready !== 1'b1) $display("FAIL reset_ld_ready: got %0h want 1", ld_wb_ready); else n_pass++;
    n_checks++; if (reg_write !== 1'b0) $display("FAIL reset_reg_write: got %0h want 0", reg_write); else n_pass++;
    rf_clr = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_issue();
    preload(5'd3, 32'h11);
    preload(5'd4, 32'h22);
    op_ready = 1'b1;
    issue_valid = 1'b1; issue_rs1 = 5'd3; issue_rs2 = 5'd4; issue_rd = 5'd1; issue_rd_is_load = 1'b0;
    #1;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL basic_issue_ready: got %0h want 1", issue_ready); else n_pass++;
    n_checks++; if (read_index1 !== 5'd3) $display("FAIL basic_read_index1: got %0h want 3", read_index1); else n_pass++;
    tick();
    issue_valid = 1'b0;
    n_checks++; if (op_valid !== 1'b1) $display("FAIL basic_op_valid: got %0h want 1", op_valid); else n_pass++;
    n_checks++; if (op_rs1_data !== 32'h11) $display("FAIL basic_rs1: got %0h want 11", op_rs1_data); else n_pass++;
    n_checks++; if (op_rs2_data !== 32'h22) $display("FAIL basic_rs2: got %0h want 22", op_rs2_data); else n_pass++;
    tick();
    n_checks++; if (op_valid !== 1'b0) $display("FAIL basic_drain: got %0h want 0", op_valid); else n_pass++;
  endtask

  task automatic test_alu_forward();
    issue_valid = 1'b1; issue_rs1 = 5'd5; issue_rs2 = 5'd3; issue_rd = 5'd1; issue_rd_is_load = 1'b0;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEAD;
    #1;
    n_checks++; if (reg_write !== 1'b1) $display("FAIL fwd_reg_write: got %0h want 1", reg_write); else n_pass++;
    n_checks++; if (write_index !== 5'd5) $display("FAIL fwd_write_index: got %0h want 5", write_index); else n_pass++;
    tick();
    issue_valid = 1'b0; alu_wb_valid = 1'b0;
    n_checks++; if (op_rs1_data !== 32'hDEAD) $display("FAIL fwd_rs1: got %0h want dead", op_rs1_data); else n_pass++;
    n_checks++; if (op_rs2_data !== 32'h11) $display("FAIL fwd_rs2: got %0h want 11", op_rs2_data); else n_pass++;
    tick();
  endtask

  task automatic test_load_hazard();
    issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd7; issue_rd_is_load = 1'b1;
    #1;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL ld_issue_ready: got %0h want 1", issue_ready); else n_pass++;
    tick();
    issue_rs2 = 5'd7; issue_rd = 5'd2; issue_rd_is_load = 1'b0;
    ld_wb_valid = 1'b1; ld_wb_rd = 5'd7; ld_wb_data = 32'hBEEF;
    #1;
    n_checks++; if (issue_ready !== 1'b0) $display("FAIL raw_stall_a: got %0h want 0", issue_ready); else n_pass++;
    tick();
    ld_wb_valid = 1'b0;
    #1;
    n_checks++; if (reg_write !== 1'b1 || write_index !== 5'd7 || write_data !== 32'hBEEF)
      $display("FAIL ld_write: got we=%0h idx=%0h data=%0h want 1/7/beef", reg_write, write_index, write_data); else n_pass++;
    n_checks++; if (issue_ready !== 1'b0) $display("FAIL raw_stall_b: got %0h want 0", issue_ready); else n_pass++;
    tick();
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL raw_release: got %0h want 1", issue_ready); else n_pass++;
    tick();
    issue_valid = 1'b0;
    n_checks++; if (op_valid !== 1'b1 || op_rs2_data !== 32'hBEEF)
      $display("FAIL raw_rs2: got v=%0h data=%0h want 1/beef", op_valid, op_rs2_data); else n_pass++;
    tick();
  endtask

  task automatic test_fifo_full();
    // Back-to-back load issues to x10, x11, x12
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd10 + 5'(i); issue_rd_is_load = 1'b1;
      #1;
      n_checks++; if (issue_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %0h want 1", i, issue_ready); else n_pass++;
      tick();
      n_checks++; if (op_valid !== 1'b1) $display("FAIL b2b_op_valid_%0d: got %0h want 1", i, op_valid); else n_pass++;
    end
    issue_valid = 1'b0; issue_rd_is_load = 1'b0; issue_rd = 5'd0;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = 32'h1111;
    ld_wb_valid = 1'b1; ld_wb_rd = 5'd10; ld_wb_data = 32'hA0;
    #1;
    n_checks++; if (ld_wb_ready !== 1'b1) $display("FAIL fifo_ready_0: got %0h want 1", ld_wb_ready); else n_pass++;
    tick();
    ld_wb_rd = 5'd11; ld_wb_data = 32'hB0;
    #1;
    n_checks++; if (ld_wb_ready !== 1'b1) $display("FAIL fifo_ready_1: got %0h want 1", ld_wb_ready); else n_pass++;
    tick();
    ld_wb_rd = 5'd12; ld_wb_data = 32'hC0;
    #1;
    n_checks++; if (ld_wb_ready !== 1'b0) $display("FAIL fifo_full: got %0h want 0", ld_wb_ready); else n_pass++;
    tick();
    alu_wb_valid = 1'b0;
    #1;
    n_checks++; if (reg_write !== 1'b1 || write_index !== 5'd10 || write_data !== 32'hA0)
      $display("FAIL drain_0: got we=%0h idx=%0h data=%0h want 1/a/a0", reg_write, write_index, write_data); else n_pass++;
    n_checks++; if (ld_wb_ready !== 1'b0) $display("FAIL full_pop_ready: got %0h want 0", ld_wb_ready); else n_pass++;
    tick();
    issue_rs1 = 5'd10;
    #1;
    n_checks++; if (write_index !== 5'd11 || write_data !== 32'hB0)
      $display("FAIL drain_1: got idx=%0h data=%0h want b/b0", write_index, write_data); else n_pass++;
    n_checks++; if (ld_wb_ready !== 1'b1) $display("FAIL reopen_ready: got %0h want 1", ld_wb_ready); else n_pass++;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL pend10_clear: got %0h want 1", issue_ready); else n_pass++;
    tick();
    ld_wb_valid = 1'b0; issue_rs1 = 5'd12;
    #1;
    n_checks++; if (write_index !== 5'd12 || write_data !== 32'hC0)
      $display("FAIL drain_2: got idx=%0h data=%0h want c/c0", write_index, write_data); else n_pass++;
    n_checks++; if (issue_ready !== 1'b0) $display("FAIL pend12_set: got %0h want 0", issue_ready); else n_pass++;
    tick();
    n_checks++; if (reg_write !== 1'b0) $display("FAIL drain_empty: got %0h want 0", reg_write); else n_pass++;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL pend12_clear: got %0h want 1", issue_ready); else n_pass++;
    issue_rs1 = 5'd0;
    tick();
  endtask

  task automatic test_x0();
    issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd3; issue_rd = 5'd1;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd0; alu_wb_data = 32'h55;
    #1;
    n_checks++; if (reg_write !== 1'b0) $display("FAIL x0_alu_we: got %0h want 0", reg_write); else n_pass++;
    tick();
    issue_valid = 1'b0; alu_wb_valid = 1'b0;
    n_checks++; if (op_rs1_data !== 32'h0 || op_rs2_data !== 32'h11)
      $display("FAIL x0_capture: got %0h/%0h want 0/11", op_rs1_data, op_rs2_data); else n_pass++;
    ld_wb_valid = 1'b1; ld_wb_rd = 5'd0; ld_wb_data = 32'h77;
    tick();
    ld_wb_rd = 5'd13; ld_wb_data = 32'h13;
    #1;
    n_checks++; if (reg_write !== 1'b0) $display("FAIL x0_ld_we: got %0h want 0", reg_write); else n_pass++;
    tick();
    ld_wb_valid = 1'b0;
    #1;
    n_checks++; if (reg_write !== 1'b1 || write_index !== 5'd13 || write_data !== 32'h13)
      $display("FAIL x0_popped: got we=%0h idx=%0h data=%0h want 1/d/13", reg_write, write_index, write_data); else n_pass++;
    tick();
    n_checks++; if (reg_write !== 1'b0) $display("FAIL x0_empty: got %0h want 0", reg_write); else n_pass++;
  endtask

  task automatic test_reset_mid();
    preload(5'd9, 32'h99);
    op_ready = 1'b0;
    issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd9; issue_rd_is_load = 1'b1;
    tick();
    issue_valid = 1'b0; issue_rd_is_load = 1'b0; issue_rd = 5'd0;
    n_checks++; if (op_valid !== 1'b1) $display("FAIL mid_op_valid: got %0h want 1", op_valid); else n_pass++;
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = 32'h2;
    ld_wb_valid = 1'b1; ld_wb_rd = 5'd9; ld_wb_data = 32'h900;
    tick();
    ld_wb_rd = 5'd14; ld_wb_data = 32'hE00;
    tick();
    ld_wb_valid = 1'b0; issue_rs1 = 5'd9;
    #1;
    n_checks++; if (ld_wb_ready !== 1'b0) $display("FAIL mid_full: got %0h want 0", ld_wb_ready); else n_pass++;
    n_checks++; if (issue_ready !== 1'b0) $display("FAIL mid_pend9: got %0h want 0", issue_ready); else n_pass++;
    rst = 1'b1; alu_wb_valid = 1'b0;
    #1;
    n_checks++; if (op_valid !== 1'b0) $display("FAIL mid_rst_op_valid: got %0h want 0", op_valid); else n_pass++;
    n_checks++; if (ld_wb_ready !== 1'b1) $display("FAIL mid_rst_ld_ready: got %0h want 1", ld_wb_ready); else n_pass++;
    n_checks++; if (reg_write !== 1'b0) $display("FAIL mid_rst_we: got %0h want 0", reg_write); else n_pass++;
    tick();
    rst = 1'b0; op_ready = 1'b1;
    issue_valid = 1'b1; issue_rs1 = 5'd9; issue_rs2 = 5'd0; issue_rd = 5'd0;
    #1;
    n_checks++; if (issue_ready !== 1'b1) $display("FAIL post_rst_ready: got %0h want 1", issue_ready); else n_pass++;
    n_checks++; if (reg_write !== 1'b0) $display("FAIL post_rst_no_write: got %0h want 0", reg_write); else n_pass++;
    tick();
    issue_valid = 1'b0;
    n_checks++; if (op_valid !== 1'b1 || op_rs1_data !== 32'h99)
      $display("FAIL post_rst_capture: got v=%0h data=%0h want 1/99", op_valid, op_rs1_data); else n_pass++;
    tick();
  endtask

  initial begin
    rst = 1'b1; rf_clr = 1'b1; pl_en = 1'b0; pl_idx = 5'd0; pl_data = 32'h0;
    issue_valid = 1'b0; issue_rs1 = 5'd0; issue_rs2 = 5'd0; issue_rd = 5'd0; issue_rd_is_load = 1'b0;
    op_ready = 1'b1;
    alu_wb_valid = 1'b0; alu_wb_rd = 5'd0; alu_wb_data = 32'h0;
    ld_wb_valid = 1'b0; ld_wb_rd = 5'd0; ld_wb_data = 32'h0;
    test_reset();
    test_basic_issue();
    test_alu_forward();
    test_load_hazard();
    test_fifo_full();
    test_x0();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
